// File: rtl/llc_input_arbiter.sv
// llc_input_arbiter: rsp/round-robin req arbiter with registered output and one stall slot; LLC_ARB_STATS_EN adds grant/stall counters
module llc_input_arbiter #(
  parameter int NUM_REQ_CH = 2,
  parameter int PAYLOAD_W  = 160,
  parameter int CH_W       = 3
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            rsp_in_valid,
  output logic                            rsp_in_ready,
  input  logic [PAYLOAD_W-1:0]            rsp_in_data,
  input  logic [NUM_REQ_CH-1:0]           req_in_valid,
  output logic [NUM_REQ_CH-1:0]           req_in_ready,
  input  logic [NUM_REQ_CH*PAYLOAD_W-1:0] req_in_data,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [1:0]                      out_src,
  output logic [CH_W-1:0]                 out_ch,
  output logic [PAYLOAD_W-1:0]            out_data,
  input  logic                            park_valid,
  input  logic [CH_W-1:0]                 park_ch,
  input  logic [PAYLOAD_W-1:0]            park_data,
  input  logic                            resume,
  output logic                            stall_pending,
  output logic                            err_overflow
`ifdef LLC_ARB_STATS_EN
  ,
  output logic [NUM_REQ_CH*16-1:0]        stats_grants,
  output logic [15:0]                     stats_stall_cycles
`endif
);
  logic                 r_out_valid;
  logic [1:0]           r_out_src;
  logic [CH_W-1:0]      r_out_ch;
  logic [PAYLOAD_W-1:0] r_out_data;
  logic                 r_stall_pending;
  logic                 r_resume_ok;
  logic [CH_W-1:0]      r_stall_ch;
  logic [PAYLOAD_W-1:0] r_stall_data;
  logic                 r_err;
  logic [CH_W-1:0]      r_rr;
  logic                 w_lo_vld, w_hi_vld;
  logic [CH_W-1:0]      w_lo, w_hi, w_gnt, w_rr_nxt;
  logic [PAYLOAD_W-1:0] w_req_data;
  logic                 w_can_load, w_go, w_sel_rsp, w_sel_res, w_sel_req;
  always_comb begin
    w_lo_vld   = 1'b0;
    w_lo       = '0;
    w_hi_vld   = 1'b0;
    w_hi       = '0;
    w_req_data = '0;
    for (int i = NUM_REQ_CH - 1; i >= 0; i--) begin
      if (req_in_valid[i]) begin
        w_lo_vld = 1'b1;
        w_lo     = CH_W'(i);
      end
      if (req_in_valid[i] && CH_W'(i) >= r_rr) begin
        w_hi_vld = 1'b1;
        w_hi     = CH_W'(i);
      end
    end
    w_gnt = w_hi_vld ? w_hi : w_lo;
    for (int i = 0; i < NUM_REQ_CH; i++)
      if (CH_W'(i) == w_gnt) w_req_data = req_in_data[i*PAYLOAD_W +: PAYLOAD_W];
  end
  assign w_rr_nxt      = (w_gnt == CH_W'(NUM_REQ_CH - 1)) ? '0 : w_gnt + 1'b1;
  assign w_can_load    = !r_out_valid | out_ready;
  assign w_go          = rst & w_can_load;
  assign w_sel_rsp     = rsp_in_valid;
  assign w_sel_res     = !rsp_in_valid & r_stall_pending & r_resume_ok;
  assign w_sel_req     = !rsp_in_valid & !r_stall_pending & w_lo_vld;
  assign rsp_in_ready  = w_go & w_sel_rsp;
  assign req_in_ready  = (w_go & w_sel_req) ? NUM_REQ_CH'(1) << w_gnt : '0;
  assign out_valid     = r_out_valid;
  assign out_src       = r_out_src;
  assign out_ch        = r_out_ch;
  assign out_data      = r_out_data;
  assign stall_pending = r_stall_pending;
  assign err_overflow  = r_err;
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_out_valid     <= 1'b0;
      r_out_src       <= '0;
      r_out_ch        <= '0;
      r_out_data      <= '0;
      r_stall_pending <= 1'b0;
      r_resume_ok     <= 1'b0;
      r_stall_ch      <= '0;
      r_stall_data    <= '0;
      r_err           <= 1'b0;
      r_rr            <= '0;
    end else begin
      if (w_can_load) begin
        r_out_valid <= w_sel_rsp | w_sel_res | w_sel_req;
        r_out_src   <= w_sel_rsp ? 2'd0 : w_sel_res ? 2'd2 : 2'd1;
        r_out_ch    <= w_sel_rsp ? '0 : w_sel_res ? r_stall_ch : w_gnt;
        r_out_data  <= w_sel_rsp ? rsp_in_data : w_sel_res ? r_stall_data : w_req_data;
        if (w_sel_req) r_rr <= w_rr_nxt;
      end
      if (!r_stall_pending && park_valid) begin
        r_stall_pending <= 1'b1;
        r_stall_ch      <= park_ch;
        r_stall_data    <= park_data;
      end
      if (r_stall_pending && park_valid) r_err <= 1'b1;
      if (r_stall_pending && resume) r_resume_ok <= 1'b1;
      if (w_can_load && w_sel_res) begin
        r_stall_pending <= 1'b0;
        r_resume_ok     <= 1'b0;
      end
    end
  end
`ifdef LLC_ARB_STATS_EN
  logic [NUM_REQ_CH*16-1:0] r_grants;
  logic [15:0]              r_stall_cyc;
  assign stats_grants       = r_grants;
  assign stats_stall_cycles = r_stall_cyc;
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_grants    <= '0;
      r_stall_cyc <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ_CH; i++)
        if (req_in_ready[i] && r_grants[i*16 +: 16] != 16'hFFFF)
          r_grants[i*16 +: 16] <= r_grants[i*16 +: 16] + 16'd1;
      if (r_stall_pending && r_stall_cyc != 16'hFFFF) r_stall_cyc <= r_stall_cyc + 16'd1;
    end
  end
`endif
endmodule

// File: tb/tb_llc_input_arbiter.sv
// tb_llc_input_arbiter: directed checks of priority, round robin, backpressure and stall slot
module tb_llc_input_arbiter;
  localparam int N  = 2;
  localparam int PW = 160;
  localparam int CW = 3;
  logic            clk = 1'b0;
  logic            rst;
  logic            rsp_in_valid;
  logic            rsp_in_ready;
  logic [PW-1:0]   rsp_in_data;
  logic [N-1:0]    req_in_valid;
  logic [N-1:0]    req_in_ready;
  logic [N*PW-1:0] req_in_data;
  logic            out_valid;
  logic            out_ready;
  logic [1:0]      out_src;
  logic [CW-1:0]   out_ch;
  logic [PW-1:0]   out_data;
  logic            park_valid;
  logic [CW-1:0]   park_ch;
  logic [PW-1:0]   park_data;
  logic            resume;
  logic            stall_pending;
  logic            err_overflow;
  int total = 0;
  int bad   = 0;
  llc_input_arbiter #(.NUM_REQ_CH(N), .PAYLOAD_W(PW), .CH_W(CW)) dut (
    .clk(clk), .rst(rst),
    .rsp_in_valid(rsp_in_valid), .rsp_in_ready(rsp_in_ready), .rsp_in_data(rsp_in_data),
    .req_in_valid(req_in_valid), .req_in_ready(req_in_ready), .req_in_data(req_in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_src(out_src), .out_ch(out_ch), .out_data(out_data),
    .park_valid(park_valid), .park_ch(park_ch), .park_data(park_data), .resume(resume),
    .stall_pending(stall_pending), .err_overflow(err_overflow)
  );
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [PW-1:0] obs, input logic [PW-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic chk_out(input string tag, input logic [1:0] src, input logic [CW-1:0] ch, input logic [PW-1:0] data);
    chk({tag, "_valid"}, PW'(out_valid), PW'(1));
    chk({tag, "_src"}, PW'(out_src), PW'(src));
    chk({tag, "_ch"}, PW'(out_ch), PW'(ch));
    chk({tag, "_data"}, out_data, data);
  endtask
  initial begin
    rst = 1'b0; rsp_in_valid = 1'b1; rsp_in_data = PW'(8'hA5);
    req_in_valid = '1; req_in_data = {PW'(16'h101), PW'(16'h100)};
    out_ready = 1'b1; park_valid = 1'b0; park_ch = '0; park_data = '0; resume = 1'b0;
    tick(); tick();
    chk("rst_out_valid", PW'(out_valid), '0);
    chk("rst_out_src", PW'(out_src), '0);
    chk("rst_out_ch", PW'(out_ch), '0);
    chk("rst_out_data", out_data, '0);
    chk("rst_stall", PW'(stall_pending), '0);
    chk("rst_err", PW'(err_overflow), '0);
    chk("rst_rsp_ready", PW'(rsp_in_ready), '0);
    chk("rst_req_ready", PW'(req_in_ready), '0);
    rst = 1'b1; req_in_valid = '0;
    #1 chk("rsp_ready", PW'(rsp_in_ready), PW'(1));
    tick();
    chk_out("rsp_out", 2'd0, '0, PW'(8'hA5));
    rsp_in_valid = 1'b0; req_in_valid = 2'b11;
    #1 chk("rr0_ready", PW'(req_in_ready), PW'(2'b01));
    tick();
    chk_out("rr0_out", 2'd1, 3'd0, PW'(16'h100));
    #1 chk("rr1_ready", PW'(req_in_ready), PW'(2'b10));
    tick();
    chk_out("rr1_out", 2'd1, 3'd1, PW'(16'h101));
    #1 chk("rr_wrap_ready", PW'(req_in_ready), PW'(2'b01));
    tick();
    chk_out("rr2_out", 2'd1, 3'd0, PW'(16'h100));
    rsp_in_valid = 1'b1; rsp_in_data = PW'(8'h55); req_in_valid = 2'b01;
    #1 chk("pri_rsp_ready", PW'(rsp_in_ready), PW'(1));
    chk("pri_req_ready", PW'(req_in_ready), '0);
    tick();
    chk_out("pri_rsp_out", 2'd0, '0, PW'(8'h55));
    rsp_in_valid = 1'b0;
    #1 chk("pri_req_next", PW'(req_in_ready), PW'(2'b01));
    tick();
    chk_out("pri_req_out", 2'd1, 3'd0, PW'(16'h100));
    out_ready = 1'b0; req_in_valid = 2'b11; rsp_in_valid = 1'b1; rsp_in_data = PW'(8'h66);
    for (int k = 0; k < 3; k++) begin
      #1 chk("bp_rsp_ready", PW'(rsp_in_ready), '0);
      chk("bp_req_ready", PW'(req_in_ready), '0);
      tick();
      chk_out("bp_hold", 2'd1, 3'd0, PW'(16'h100));
    end
    out_ready = 1'b1;
    #1 chk("bp_release_ready", PW'(rsp_in_ready), PW'(1));
    tick();
    chk_out("bp_rsp_out", 2'd0, '0, PW'(8'h66));
    rsp_in_valid = 1'b0;
    #1 chk("bp_req_ch1", PW'(req_in_ready), PW'(2'b10));
    tick();
    chk_out("bp_req_out", 2'd1, 3'd1, PW'(16'h101));
    req_in_valid = '0; park_valid = 1'b1; park_ch = 3'd1; park_data = PW'(8'h77);
    tick();
    park_valid = 1'b0;
    chk("park_pending", PW'(stall_pending), PW'(1));
    req_in_valid = 2'b11; rsp_in_valid = 1'b1; rsp_in_data = PW'(8'h88);
    #1 chk("park_req_blocked", PW'(req_in_ready), '0);
    chk("park_rsp_flows", PW'(rsp_in_ready), PW'(1));
    tick();
    chk_out("park_rsp_out", 2'd0, '0, PW'(8'h88));
    rsp_in_valid = 1'b0; resume = 1'b1;
    #1 chk("resume_req_blocked", PW'(req_in_ready), '0);
    tick();
    resume = 1'b0;
    chk("resume_idle_valid", PW'(out_valid), '0);
    #1 chk("reissue_req_blocked", PW'(req_in_ready), '0);
    tick();
    chk_out("reissue_out", 2'd2, 3'd1, PW'(8'h77));
    chk("reissue_cleared", PW'(stall_pending), '0);
    #1 chk("post_resume_ready", PW'(req_in_ready), PW'(2'b01));
    tick();
    chk_out("post_resume_out", 2'd1, 3'd0, PW'(16'h100));
    req_in_valid = '0; park_valid = 1'b1; resume = 1'b1; park_ch = 3'd1; park_data = PW'(8'h77);
    tick();
    park_valid = 1'b0; resume = 1'b0;
    chk("park_resume_pending", PW'(stall_pending), PW'(1));
    tick();
    chk("park_resume_ignored", PW'(out_valid), '0);
    chk("park_resume_still", PW'(stall_pending), PW'(1));
    park_valid = 1'b1; park_ch = 3'd0; park_data = PW'(8'h99);
    tick();
    park_valid = 1'b0;
    chk("ovf_err", PW'(err_overflow), PW'(1));
    resume = 1'b1;
    tick();
    resume = 1'b0;
    tick();
    chk_out("ovf_slot_kept", 2'd2, 3'd1, PW'(8'h77));
    chk("ovf_sticky", PW'(err_overflow), PW'(1));
    park_valid = 1'b1;
    tick();
    park_valid = 1'b0; rst = 1'b0;
    tick();
    chk("rst2_err", PW'(err_overflow), '0);
    chk("rst2_stall", PW'(stall_pending), '0);
    chk("rst2_valid", PW'(out_valid), '0);
    rst = 1'b1;
    tick();
    chk("rst2_after", PW'(err_overflow), '0);
    chk("rst2_idle", PW'(out_valid), '0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
